// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns architectural HI/LO and holds
// busy high for a fixed latency while a mult/div result is pending.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  start,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hiPend_q, loPend_q;
  logic [31:0]   hiPend_d, loPend_d;
  logic          divZero_q, divZero_d;

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic        [31:0] magA, magB, sDivisor, uDivisor;
  logic        [31:0] sQuot, sRem, uQuot, uRem;
  logic               bIsZero;

  // Signed division works on magnitudes and fixes signs afterwards, so that
  // INT_MIN / -1 wraps to 0x80000000 and the remainder follows the dividend.
  always_comb begin
    bIsZero  = (B == 32'd0);
    prodS    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prodU    = {32'd0, A} * {32'd0, B};
    magA     = A[31] ? (~A + 32'd1) : A;
    magB     = B[31] ? (~B + 32'd1) : B;
    sDivisor = bIsZero ? 32'd1 : magB;
    uDivisor = bIsZero ? 32'd1 : B;
    sQuot    = magA / sDivisor;
    sRem     = magA % sDivisor;
    uQuot    = A / uDivisor;
    uRem     = A % uDivisor;
  end

  always_comb begin
    hiPend_d  = hiPend_q;
    loPend_d  = loPend_q;
    divZero_d = 1'b0;
    case (start)
      OP_MULT:  {hiPend_d, loPend_d} = prodS;
      OP_MULTU: {hiPend_d, loPend_d} = prodU;
      OP_DIV: begin
        loPend_d  = (A[31] ^ B[31]) ? (~sQuot + 32'd1) : sQuot;
        hiPend_d  = A[31] ? (~sRem + 32'd1) : sRem;
        divZero_d = bIsZero;
      end
      OP_DIVU: begin
        loPend_d  = uQuot;
        hiPend_d  = uRem;
        divZero_d = bIsZero;
      end
      default: ;
    endcase
  end

  // A committed op always runs to completion; req only gates new commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      cnt_q     <= '0;
      hiPend_q  <= 32'd0;
      loPend_q  <= 32'd0;
      divZero_q <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req) begin
            case (start)
              OP_MULT, OP_MULTU: begin
                hiPend_q  <= hiPend_d;
                loPend_q  <= loPend_d;
                divZero_q <= 1'b0;
                cnt_q     <= CW'(MULT_CYCLES);
                busy      <= 1'b1;
                state_q   <= BUSY;
              end
              OP_DIV, OP_DIVU: begin
                hiPend_q  <= hiPend_d;
                loPend_q  <= loPend_d;
                divZero_q <= divZero_d;
                cnt_q     <= CW'(DIV_CYCLES);
                busy      <= 1'b1;
                state_q   <= BUSY;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt_q == CW'(1)) begin
            if (!divZero_q) begin
              HI <= hiPend_q;
              LO <= loPend_q;
            end
            cnt_q   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, HI/LO hold during busy, signed and
// unsigned arithmetic, divide-by-zero, req gating and back-to-back issue.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  start;
  logic        req;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .req(req),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic r,
                               input logic [31:0] a, input logic [31:0] b);
    start = op;
    req   = r;
    A     = a;
    B     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Counts edges until busy falls, checking HI/LO hold their old values.
  task automatic waitIdle(input string tag, input int expN,
                          input logic [31:0] holdHi, input logic [31:0] holdLo);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      checkOutput({tag, "_holdHI"}, HI, holdHi);
      checkOutput({tag, "_holdLO"}, LO, holdLo);
      tick();
      n++;
    end
    checkOutput({tag, "_busyCycles"}, 32'(n), 32'(expN));
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, 1'b0, a, b);
    tick();
    applyStimulus(OP_NONE, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(OP_NONE, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_HI", HI, 32'd0);
    checkOutput("rst_LO", LO, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a divide clears everything asynchronously
    issue(OP_MTHI, 32'h0000_0099, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    checkOutput("div_started", {31'd0, busy}, 32'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    #2;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_HI", HI, 32'd0);
    checkOutput("midrst_LO", LO, 32'd0);
    tick();
    reset = 1'b0;
    issue(OP_MTLO, 32'd5, 32'd0);
    checkOutput("mtlo_LO", LO, 32'd5);
    checkOutput("mtlo_HI", HI, 32'd0);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    waitIdle("mult", 5, 32'd0, 32'd5);
    checkOutput("mult_HI", HI, 32'hFFFF_FFFF);
    checkOutput("mult_LO", LO, 32'hFFFF_FFFE);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitIdle("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    checkOutput("multu_HI", HI, 32'h0000_0001);
    checkOutput("multu_LO", LO, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle("div", 10, 32'h0000_0001, 32'hFFFF_FFFE);
    checkOutput("div_LO", LO, 32'hFFFF_FFFD);
    checkOutput("div_HI", HI, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    waitIdle("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    checkOutput("divu_LO", LO, 32'h7FFF_FFFC);
    checkOutput("divu_HI", HI, 32'h0000_0001);

    // Divide by zero runs full latency and leaves HI/LO alone
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    checkOutput("preload_HI", HI, 32'h11);
    checkOutput("preload_LO", LO, 32'h22);
    issue(OP_DIV, 32'd5, 32'd0);
    waitIdle("div0", 10, 32'h11, 32'h22);
    checkOutput("div0_HI", HI, 32'h11);
    checkOutput("div0_LO", LO, 32'h22);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle("intmin", 10, 32'h11, 32'h22);
    checkOutput("intmin_LO", LO, 32'h8000_0000);
    checkOutput("intmin_HI", HI, 32'h0000_0000);

    // req blocks new commands
    applyStimulus(OP_MULT, 1'b1, 32'd3, 32'd3);
    tick();
    checkOutput("reqmult_busy", {31'd0, busy}, 32'd0);
    applyStimulus(OP_MTHI, 1'b1, 32'h55, 32'd0);
    tick();
    applyStimulus(OP_NONE, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("reqmthi_HI", HI, 32'h0000_0000);
    checkOutput("reqmult_LO", LO, 32'h8000_0000);

    // req raised in the 2nd busy cycle does not abort
    issue(OP_MULT, 32'd6, 32'd7);
    tick();
    applyStimulus(OP_NONE, 1'b1, 32'd0, 32'd0);
    waitIdle("reqbusy", 4, 32'h0, 32'h8000_0000);
    applyStimulus(OP_NONE, 1'b0, 32'd0, 32'd0);
    checkOutput("reqbusy_HI", HI, 32'd0);
    checkOutput("reqbusy_LO", LO, 32'd42);

    // DIV held during MULT busy is ignored until the first idle edge
    issue(OP_MULT, 32'd3, 32'd4);
    applyStimulus(OP_DIV, 1'b0, 32'd8, 32'd2);
    waitIdle("b2b_mult", 5, 32'd0, 32'd42);
    checkOutput("b2b_mult_HI", HI, 32'd0);
    checkOutput("b2b_mult_LO", LO, 32'd12);
    tick();
    applyStimulus(OP_NONE, 1'b0, 32'd0, 32'd0);
    checkOutput("b2b_div_accept", {31'd0, busy}, 32'd1);
    waitIdle("b2b_div", 10, 32'd0, 32'd12);
    checkOutput("b2b_div_LO", LO, 32'd4);
    checkOutput("b2b_div_HI", HI, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
